filt_sched: RTL and testbench
=============================

FILT_SCHED -- requirements
Module: filt_sched

Interface
REQ-001 Parameter DATA_W, default 16: sample/result width.
REQ-002 Parameter START_LEN, default 2: number of cycles f_start is held high per job.
REQ-003 Parameter TIMEOUT, default 255: maximum WAIT cycles before a job is aborted.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: asynchronous reset, active-high.
REQ-006 Port s_valid, input, 1: input sample valid.
REQ-007 Port s_data, input, DATA_W: input sample.
REQ-008 Port s_ready, output, 1: scheduler can accept a sample.
REQ-009 Port cfg_sel, input, 2: requested filter (00 LPF, 01 HPF, 10 BPF, 11 bypass).
REQ-010 Port f_start, output, 1: start to the filters datapath.
REQ-011 Port f_val, output, DATA_W: sample held for the filters datapath.
REQ-012 Port f_select, output, 2: filter select applied to the datapath.
REQ-013 Port f_done, input, 1: datapath done.
REQ-014 Port f_result, input, DATA_W: datapath result.
REQ-015 Port m_valid, output, 1: output result valid.
REQ-016 Port m_data, output, DATA_W: output result.
REQ-017 Port m_ready, input, 1: downstream accepts the result.
REQ-018 Port busy, output, 1: high in any state other than IDLE.
REQ-019 Port timeout_err, output, 1: sticky flag, set when a job times out.
REQ-020 Port job_cnt, output, 16: completed-job counter.
REQ-021 Port tmo_cnt, output, 16: timeout counter.

Function
REQ-022 The FSM SHALL have states IDLE, START, WAIT and OUT.
REQ-023 s_ready SHALL be high only in IDLE with rst low.
REQ-024 In IDLE, on s_valid=1 the scheduler SHALL capture s_data into f_val and cfg_sel into f_select in the same cycle.
REQ-025 cfg_sel changes SHALL have no effect on a job already accepted.
REQ-026 If the captured select is 11, the FSM SHALL go IDLE->OUT with m_data=s_data, so m_valid is high 1 cycle after acceptance and f_start never asserts.
REQ-027 Otherwise the FSM SHALL go IDLE->START, hold f_start high for exactly START_LEN consecutive cycles, then enter WAIT.
REQ-028 f_val and f_select SHALL stay stable from acceptance until the FSM returns to IDLE.
REQ-029 f_done SHALL be ignored outside WAIT.
REQ-030 In WAIT, on f_done=1 the scheduler SHALL register f_result into m_data and go to OUT, so m_valid is high in the cycle after f_done.
REQ-031 A WAIT cycle counter SHALL clear on WAIT entry.
- If TIMEOUT cycles elapse with no f_done: set timeout_err, go to IDLE, assert no m_valid, drop the sample.
- If f_done arrives on the TIMEOUT-th cycle, done wins.
REQ-032 In OUT, m_valid and m_data SHALL hold stable until m_ready=1, then the FSM SHALL go to IDLE on the next edge; no new sample is accepted in that same cycle.
REQ-033 Throughput SHALL be at most one job in flight, with no output buffering beyond m_data.
REQ-034 timeout_err SHALL clear only on reset.

Reset
REQ-035 While rst is high, and immediately on its assertion, the scheduler SHALL force state=IDLE and drive these values:
- s_ready=0, f_start=0, f_val=0, f_select=00, m_valid=0, m_data=0;
- busy=0, timeout_err=0, job_cnt=0, tmo_cnt=0.
REQ-036 Reset asserted mid-job SHALL abandon the job with no m_valid and no counter update.

Configuration
REQ-037 With macro FILT_SCHED_STATS_EN defined, the counters SHALL behave as follows:
- job_cnt increments on each OUT handshake (m_valid & m_ready);
- tmo_cnt increments on each timeout;
- both saturate at 16'hFFFF.
REQ-038 Without FILT_SCHED_STATS_EN, job_cnt and tmo_cnt SHALL be constant 0 with no counter logic, and all other behaviour SHALL be identical.

Verification
REQ-039 The bench SHALL cover each scenario below:
- Bypass: cfg_sel=11, s_data=16'h1234 with s_valid for 1 cycle, m_ready=1 -> m_valid high next cycle with m_data=16'h1234, f_start never high.
- LPF job: cfg_sel=00, s_data=16'h0100; f_done pulsed 30 cycles after WAIT entry with f_result=16'h00AA -> f_start high exactly 2 cycles, f_select=00, m_data=16'h00AA one cycle after f_done.
- Backpressure: m_ready=0 for 10 cycles after m_valid -> m_data stable, s_ready=0 throughout; m_ready=1 -> IDLE next cycle, with job_cnt=1 when the macro is defined.
- Timeout: cfg_sel=01, f_done never asserted -> timeout_err=1 after 255 WAIT cycles, no m_valid, s_ready=1 afterwards, with tmo_cnt=1 when the macro is defined.
- Select change mid-job: cfg_sel 10->00 during WAIT -> f_select stays 10 until the job ends; the next job uses 00.
- Reset mid-WAIT: rst asserted asynchronously -> all outputs take reset values immediately; after release, a new sample is accepted normally.

Source files
------------

// File: rtl/filt_sched.sv
// ---------------------------------------------------------------------------
// filt_sched -- single-job scheduler in front of a filter datapath.
//
// Accepts one sample at a time. The sample is either passed straight through
// (bypass select) or handed to the filters datapath with a START_LEN-cycle
// start pulse. The scheduler then waits up to TIMEOUT cycles for the datapath
// to finish and presents the result downstream. At most one job is in
// flight, and m_data is the only output storage.
//
// Optional feature macro: FILT_SCHED_STATS_EN
//   defined   -> job_cnt / tmo_cnt are saturating 16-bit event counters
//   undefined -> job_cnt / tmo_cnt are tied to zero
//
// Handshake semantics (both s_* and m_* sides):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. Once the producer raises valid, it holds valid and data stable
//   until that edge. Ready may depend on state only, never on valid.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   s_valid/s_data    : input sample stream
//   s_ready           : high only in IDLE while rst is low
//   cfg_sel           : requested filter (00 LPF, 01 HPF, 10 BPF, 11 bypass)
//   f_start           : start pulse to datapath, START_LEN cycles long
//   f_val, f_select   : sample and select held for the datapath
//   f_done, f_result  : datapath completion and result (sampled in WAIT only)
//   m_valid/m_data    : output result stream
//   m_ready           : downstream accepts the result
//   busy              : FSM is not in IDLE
//   timeout_err       : sticky, set when a job times out; cleared by reset
//   job_cnt, tmo_cnt  : completed-job / timeout counters
//   state_dbg         : current FSM state encoding (debug visibility)
// ---------------------------------------------------------------------------
module filt_sched #(
  parameter int DATA_W    = 16,
  parameter int START_LEN = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic [1:0]        cfg_sel,
  output logic              f_start,
  output logic [DATA_W-1:0] f_val,
  output logic [1:0]        f_select,
  input  logic              f_done,
  input  logic [DATA_W-1:0] f_result,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic              timeout_err,
  output logic [15:0]       job_cnt,
  output logic [15:0]       tmo_cnt,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam logic [1:0] SEL_BYPASS = 2'b11;

  // Counter widths sized to hold 0 .. LEN-1.
  localparam int SCW = (START_LEN > 1) ? $clog2(START_LEN) : 1;
  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SCW-1:0] START_LAST = SCW'(START_LEN - 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT - 1);

  state_t         state;
  state_t         state_nx;
  logic [SCW-1:0] start_cnt;
  logic [WCW-1:0] wait_cnt;

  logic accept;    // sample taken this cycle
  logic done_hit;  // datapath result taken this cycle
  logic tmo_hit;   // job aborted this cycle

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // -------------------------------------------------------------------------
  // FSM: next state and per-cycle event strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    done_hit = 1'b0;
    tmo_hit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_valid) begin
          accept   = 1'b1;
          state_nx = (cfg_sel == SEL_BYPASS) ? ST_OUT : ST_START;
        end
      end
      ST_START: begin
        if (start_cnt == START_LAST) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        // Done is checked first so a completion on the last allowed cycle
        // still delivers its result instead of timing out.
        if (f_done) begin
          done_hit = 1'b1;
          state_nx = ST_OUT;
        end else if (wait_cnt == WAIT_LAST) begin
          tmo_hit  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (m_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Phase counters: both read zero on entry to their state and count up only
  // while the FSM stays in that state.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      start_cnt <= (state == ST_START && state_nx == ST_START) ?
                   start_cnt + 1'b1 : '0;
      wait_cnt  <= (state == ST_WAIT && state_nx == ST_WAIT) ?
                   wait_cnt + 1'b1 : '0;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers. f_val / f_select load only on acceptance, so they
  // stay put for the whole job regardless of cfg_sel activity.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_val       <= '0;
      f_select    <= 2'b00;
      m_data      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (accept) begin
        f_val    <= s_data;
        f_select <= cfg_sel;
      end
      if (accept && cfg_sel == SEL_BYPASS) m_data <= s_data;
      else if (done_hit)                   m_data <= f_result;
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Optional statistics counters (saturating)
  // -------------------------------------------------------------------------
`ifdef FILT_SCHED_STATS_EN
  logic out_hs;
  assign out_hs = (state == ST_OUT) && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_cnt <= 16'h0000;
      tmo_cnt <= 16'h0000;
    end else begin
      if (out_hs && job_cnt != 16'hFFFF)  job_cnt <= job_cnt + 16'h0001;
      if (tmo_hit && tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'h0001;
    end
  end
`else
  assign job_cnt = 16'h0000;
  assign tmo_cnt = 16'h0000;
`endif

  // -------------------------------------------------------------------------
  // State-decoded outputs
  // -------------------------------------------------------------------------
  assign s_ready   = (state == ST_IDLE) && !rst;
  assign f_start   = (state == ST_START);
  assign m_valid   = (state == ST_OUT);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_filt_sched.sv
// ---------------------------------------------------------------------------
// tb_filt_sched -- directed self-checking bench for filt_sched.
// Inputs are driven 1 ns after the rising edge; outputs are checked at the
// same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_filt_sched;

  localparam int DATA_W = 16;

`ifdef FILT_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT signals
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data  = '0;
  logic              s_ready;
  logic [1:0]        cfg_sel = 2'b00;
  logic              f_start;
  logic [DATA_W-1:0] f_val;
  logic [1:0]        f_select;
  logic              f_done   = 1'b0;
  logic [DATA_W-1:0] f_result = '0;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready  = 1'b0;
  logic              busy;
  logic              timeout_err;
  logic [15:0]       job_cnt;
  logic [15:0]       tmo_cnt;
  logic [1:0]        state_dbg;

  filt_sched #(.DATA_W(DATA_W), .START_LEN(2), .TIMEOUT(255)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .cfg_sel    (cfg_sel),
    .f_start    (f_start),
    .f_val      (f_val),
    .f_select   (f_select),
    .f_done     (f_done),
    .f_result   (f_result),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .busy       (busy),
    .timeout_err(timeout_err),
    .job_cnt    (job_cnt),
    .tmo_cnt    (tmo_cnt),
    .state_dbg  (state_dbg)
  );

  // Cycle monitors for f_start / m_valid, sampled on the falling edge.
  int fs_cycles = 0;
  int mv_cycles = 0;
  always @(negedge clk) begin
    if (f_start) fs_cycles++;
    if (m_valid) mv_cycles++;
  end

  int checks = 0;
  int errors = 0;
  int jobs   = 0;   // expected completed jobs since last reset
  int tmos   = 0;   // expected timeouts since last reset
  int fs_base;
  int mv_base;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample for exactly one accepting edge.
  task automatic send(input logic [1:0] sel, input logic [DATA_W-1:0] d);
    s_valid = 1'b1;
    cfg_sel = sel;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_job_cnt"}, job_cnt, STATS ? 32'(jobs) : 32'd0);
    check({tag, "_tmo_cnt"}, tmo_cnt, STATS ? 32'(tmos) : 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"},  s_ready,     0);
    check({tag, "_f_start"},  f_start,     0);
    check({tag, "_f_val"},    f_val,       0);
    check({tag, "_f_select"}, f_select,    0);
    check({tag, "_m_valid"},  m_valid,     0);
    check({tag, "_m_data"},   m_data,      0);
    check({tag, "_busy"},     busy,        0);
    check({tag, "_tmo_err"},  timeout_err, 0);
    check({tag, "_job_cnt"},  job_cnt,     0);
    check({tag, "_tmo_cnt"},  tmo_cnt,     0);
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (2) tick();
    check_reset_vals("rst");
    rst = 1'b0;
    #1;
    check("rst_rel_s_ready", s_ready, 1);

    // ---------------- bypass ----------------
    fs_base = fs_cycles;
    m_ready = 1'b1;
    send(2'b11, 16'h1234);
    check("byp_m_valid", m_valid, 1);
    check("byp_m_data",  m_data,  16'h1234);
    check("byp_s_ready", s_ready, 0);
    tick();
    jobs++;
    check("byp_idle_m_valid", m_valid, 0);
    check("byp_idle_s_ready", s_ready, 1);
    check("byp_f_start_cycles", 32'(fs_cycles - fs_base), 0);
    check_counters("byp");

    // ---------------- LPF job ----------------
    fs_base = fs_cycles;
    send(2'b00, 16'h0100);
    check("lpf_f_start",  f_start,  1);
    check("lpf_f_select", f_select, 2'b00);
    check("lpf_f_val",    f_val,    16'h0100);
    check("lpf_busy",     busy,     1);
    tick();
    check("lpf_f_start2", f_start, 1);
    tick();                               // now in WAIT
    check("lpf_f_start_off", f_start, 0);
    check("lpf_start_cycles", 32'(fs_cycles - fs_base), 2);
    mv_base = mv_cycles;
    repeat (30) tick();
    check("lpf_wait_no_mv", 32'(mv_cycles - mv_base), 0);
    f_done   = 1'b1;
    f_result = 16'h00AA;
    tick();
    f_done   = 1'b0;
    f_result = 16'h0000;
    check("lpf_m_valid", m_valid, 1);
    check("lpf_m_data",  m_data,  16'h00AA);
    tick();
    jobs++;
    check("lpf_idle", busy, 0);
    check_counters("lpf");

    // ---------------- backpressure ----------------
    m_ready = 1'b0;
    send(2'b00, 16'h0055);
    repeat (2) tick();                    // START -> WAIT
    f_done   = 1'b1;
    f_result = 16'hBEEF;
    tick();
    f_done   = 1'b0;
    f_result = 16'h0000;
    s_valid  = 1'b1;                      // must not be taken while in OUT
    s_data   = 16'h9999;
    for (int i = 0; i < 10; i++) begin
      check("bp_m_valid", m_valid, 1);
      check("bp_m_data",  m_data,  16'hBEEF);
      check("bp_s_ready", s_ready, 0);
      tick();
    end
    m_ready = 1'b1;
    tick();                               // handshake edge
    s_valid = 1'b0;
    jobs++;
    check("bp_done_m_valid", m_valid, 0);
    check("bp_done_s_ready", s_ready, 1);
    check("bp_f_val_kept",   f_val,   16'h0055);
    check_counters("bp");

    // ---------------- done on last WAIT cycle ----------------
    send(2'b01, 16'h0321);
    repeat (2) tick();                    // WAIT entry
    repeat (254) tick();                  // 254 WAIT cycles elapsed
    f_done   = 1'b1;
    f_result = 16'h0D0E;
    tick();                               // 255th WAIT cycle ends with done
    f_done   = 1'b0;
    check("dw_m_valid", m_valid,     1);
    check("dw_m_data",  m_data,      16'h0D0E);
    check("dw_tmo_err", timeout_err, 0);
    tick();
    jobs++;
    check_counters("dw");

    // ---------------- timeout ----------------
    mv_base = mv_cycles;
    send(2'b01, 16'h0777);
    repeat (2) tick();                    // WAIT entry
    repeat (254) tick();
    check("tmo_still_busy", busy,        1);
    check("tmo_not_yet",    timeout_err, 0);
    tick();
    tmos++;
    check("tmo_err",     timeout_err, 1);
    check("tmo_busy",    busy,        0);
    check("tmo_s_ready", s_ready,     1);
    check("tmo_no_mv",   32'(mv_cycles - mv_base), 0);
    check_counters("tmo");
    // f_done outside WAIT must be ignored
    f_done = 1'b1;
    tick();
    f_done = 1'b0;
    check("tmo_done_ignored", busy, 0);
    check("tmo_err_sticky", timeout_err, 1);

    // ---------------- select change mid-job ----------------
    send(2'b10, 16'h0ABC);
    repeat (2) tick();                    // WAIT
    cfg_sel = 2'b00;
    for (int i = 0; i < 5; i++) begin
      check("sel_hold", f_select, 2'b10);
      tick();
    end
    f_done   = 1'b1;
    f_result = 16'h1111;
    tick();
    f_done   = 1'b0;
    check("sel_out_f_select", f_select, 2'b10);
    check("sel_out_m_data",   m_data,   16'h1111);
    tick();
    jobs++;
    check_counters("sel");
    send(2'b00, 16'h0202);
    check("sel_next_f_select", f_select, 2'b00);
    check("sel_next_f_val",    f_val,    16'h0202);

    // ---------------- reset mid-WAIT ----------------
    repeat (2) tick();                    // WAIT
    repeat (3) tick();
    #3;                                   // mid-cycle, away from any edge
    rst = 1'b1;
    #1;
    check_reset_vals("arst");
    jobs = 0;
    tmos = 0;
    tick();
    rst = 1'b0;
    #1;
    check("arst_rel_s_ready", s_ready, 1);
    m_ready = 1'b1;
    send(2'b11, 16'h5A5A);
    check("arst_byp_m_valid", m_valid, 1);
    check("arst_byp_m_data",  m_data,  16'h5A5A);
    tick();
    jobs++;
    check_counters("arst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
